// File: rtl/emesh2packet_pipe.sv
// Emesh bundle to packet encoder with a registered output stage and a
// 2-entry skid buffer (M = output register, S = skid register).
module emesh2packet_pipe #(
  parameter int AW = 32,
  parameter int PW = 2*AW+40
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          access_in,
  input  logic          write_in,
  input  logic [1:0]    datamode_in,
  input  logic [4:0]    ctrlmode_in,
  input  logic [AW-1:0] dstaddr_in,
  input  logic [AW-1:0] srcaddr_in,
  input  logic [AW-1:0] data_in,
  output logic          wait_out,
  output logic          access_out,
  output logic [PW-1:0] packet_out,
  input  logic          wait_in
);

  // Encoding bit 0 is M valid, bit 1 is S valid, so the outputs come straight
  // off the state flops.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] m_q, m_d;
  logic [PW-1:0] s_q, s_d;
  logic [PW-1:0] enc;
  logic          accept;
  logic          xfer;

  generate
    if (AW == 32) begin : g_aw32
      logic unused_ctrl4;
      assign unused_ctrl4 = ctrlmode_in[4];
      assign enc = {srcaddr_in, data_in, dstaddr_in, 1'b0,
                    ctrlmode_in[3:0], datamode_in, write_in};
    end else if (AW == 64) begin : g_aw64
      // Upper halves share slots with srcaddr on writes: a write has no
      // return address to carry, so data[63:32] rides in its place.
      logic [31:0] f2, f3;
      assign f2  = write_in ? data_in[63:32] : srcaddr_in[31:0];
      assign f3  = write_in ? 32'h0 : srcaddr_in[63:32];
      assign enc = {dstaddr_in[63:32], f3, f2, data_in[31:0], dstaddr_in[31:0],
                    ctrlmode_in, datamode_in, write_in};
    end else begin : g_bad_aw
      $error("emesh2packet_pipe: AW=%0d unsupported, use 32 or 64", AW);
      assign enc = '0;
    end
  endgenerate

  assign wait_out   = state_q[1];
  assign access_out = state_q[0];
  assign packet_out = m_q;
  assign accept     = access_in & ~wait_out;
  assign xfer       = access_out & ~wait_in;

  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          m_d     = enc;
          state_d = ONE;
        end
      end
      ONE: begin
        if (xfer && accept) begin
          m_d = enc;
        end else if (xfer) begin
          state_d = EMPTY;
        end else if (accept) begin
          s_d     = enc;
          state_d = FULL;
        end
      end
      FULL: begin
        if (xfer) begin
          m_d     = s_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: doc/emesh2packet_pipe.md
Name: emesh2packet_pipe

Overview:
Transmit-side encoder for the emesh packet format. It packs the emesh signal bundle (write, datamode, ctrlmode, dstaddr, srcaddr, data) into a PW-bit packet and presents it through a registered output stage. A 2-entry skid buffer gives full-throughput valid/wait flow control. It sits between emesh-producing logic and any packet-side fabric or FIFO; the packet-to-emesh decoder at the far end recovers the bundle.

Parameters:
AW, 32, address/data width; 32 and 64 supported, any other value gives a sim-time error message and no functional guarantee
PW, 2*AW+40, packet width (104 for AW=32, 168 for AW=64)

Ports:
clk  input  1  clock, all state on rising edge
nreset  input  1  asynchronous active-low reset
access_in  input  1  input bundle valid
write_in  input  1  1=write, 0=read
datamode_in  input  2  transfer size code
ctrlmode_in  input  5  control mode; bit 4 ignored when AW=32
dstaddr_in  input  AW  destination address
srcaddr_in  input  AW  source/return address
data_in  input  AW  write data
wait_out  output  1  backpressure to producer, registered
access_out  output  1  packet_out valid
packet_out  output  PW  encoded packet
wait_in  input  1  backpressure from consumer

Behaviour:
- Encoding for AW=32: [0] write; [2:1] datamode; [6:3] ctrlmode[3:0]; [7]=0; [39:8] dstaddr; [71:40] data; [103:72] srcaddr.
- Encoding for AW=64: [0] write; [2:1] datamode; [7:3] ctrlmode; [39:8] dstaddr[31:0]; [71:40] data[31:0].
- AW=64, field [103:72]: write ? data[63:32] : srcaddr[31:0].
- AW=64, field [135:104]: write ? 32'h0 : srcaddr[63:32].
- AW=64, field [167:136]: dstaddr[63:32].
- Encoding is combinational. Encoded words are captured into the main register M or the skid register S.
- Accept condition: access_in & ~wait_out. Output transfer condition: access_out & ~wait_in.
- wait_out = S valid, driven directly from a flop.
- access_out = M valid. packet_out = M data.
- States:
  - EMPTY: M and S both invalid.
  - ONE: M valid, S invalid.
  - FULL: M and S both valid.
- EMPTY: on accept, load M and go to ONE. Latency is 1 cycle from accepted input to access_out=1.
- ONE, transfer and accept: reload M, stay in ONE. This gives back-to-back throughput of one packet per cycle.
- ONE, transfer and no accept: go to EMPTY.
- ONE, no transfer and accept: load S, go to FULL, wait_out=1 next cycle.
- ONE, neither: hold state.
- FULL: no accept is possible. On transfer, M<=S, S invalid, go to ONE. Otherwise hold.
- packet_out must be stable while access_out=1 and wait_in=1. Packet order is strictly FIFO; no drop, no duplication.
- In EMPTY, packet_out holds its last value.
- wait_in while access_out=0 has no effect.
- Input fields are don't-care when access_in=0. access_in while wait_out=1 is ignored, and the producer must hold the bundle.
- Reset (async, any state, including mid-FULL): access_out=0, wait_out=0, packet_out=0, both entries invalidated and contents discarded. First accept is allowed in the first cycle after deassertion.

Test Plan:
- AW=32 write: write=1, datamode=2'b10, ctrlmode=5'h05, dst=32'h8000_0010, data=32'hDEAD_BEEF, src=32'h1234_5678, wait_in=0 -> next cycle access_out=1, packet_out=104'h12345678_DEADBEEF_80000010_2D. Round-trip through the decoder gives an identical bundle.
- AW=32 read with ctrlmode=5'h1F: write=0, datamode=0 -> packet_out[7:0]=8'h78 (bit 7 zero, ctrlmode[4] dropped), srcaddr in [103:72].
- Backpressure: wait_in=1, present packets A, B, C on consecutive cycles -> A in M, B in S, wait_out=1 from cycle 3 and C held. Release wait_in -> A, B, C emerge in order, wait_out drops one cycle after the first transfer.
- Streaming: 16 back-to-back accepts with wait_in=0 -> 16 consecutive access_out cycles, 1-cycle latency, wait_out never asserted.
- Reset in FULL: assert nreset=0 asynchronously mid-cycle -> access_out, wait_out and packet_out are 0 immediately. Old packets never appear after release.
- AW=64 write: dst=64'h00000001_00000020, data=64'hCAFEF00D_01234567, datamode=2'b11, ctrlmode=5'h10 -> fields f0=00000020, f1=01234567, f2=CAFEF00D, f3=0, f4=00000001, [7:0]=8'h87. The same with write=0 and src=64'hAAAA0000_BBBB0000 gives f2=BBBB0000, f3=AAAA0000.
